// File: rtl/crop_embed.sv
// Re-embeds a raster-ordered OUT_ROWS x OUT_COLS window into a full IN_ROWS x IN_COLS frame,
// padding everything outside the window and tagging each beat with coordinates and tuser markers.
module crop_embed #(
   parameter int unsigned PIXEL_BIT_WIDTH = 10,
   parameter int unsigned USER_WIDTH      = 2,
   parameter int unsigned IN_ROWS         = 20,
   parameter int unsigned IN_COLS         = 20,
   parameter int unsigned OUT_ROWS        = 10,
   parameter int unsigned OUT_COLS        = 10,
   parameter int unsigned PAD_VALUE       = 0
) (
   input  logic                         clk,
   input  logic                         s_axis_resetn,
   input  logic                         ap_start,
   output logic                         ap_done,
   output logic                         ap_idle,
   input  logic [$clog2(IN_COLS)-1:0]   crop_x0,
   input  logic [$clog2(IN_ROWS)-1:0]   crop_y0,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic [PIXEL_BIT_WIDTH-1:0]   s_axis_tdata,
   input  logic [USER_WIDTH-1:0]        s_axis_tuser,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [PIXEL_BIT_WIDTH-1:0]   m_axis_tdata,
   output logic [USER_WIDTH-1:0]        m_axis_tuser,
   output logic [$clog2(IN_COLS)-1:0]   cnt_col,
   output logic [$clog2(IN_ROWS)-1:0]   cnt_row
);

   localparam int unsigned CW = $clog2(IN_COLS);
   localparam int unsigned RW = $clog2(IN_ROWS);

   localparam logic [CW:0]   MaxX0    = (CW+1)'(IN_COLS - OUT_COLS);
   localparam logic [RW:0]   MaxY0    = (RW+1)'(IN_ROWS - OUT_ROWS);
   localparam logic [CW:0]   WinCols  = (CW+1)'(OUT_COLS);
   localparam logic [RW:0]   WinRows  = (RW+1)'(OUT_ROWS);
   localparam logic [CW-1:0] LastCol  = CW'(IN_COLS - 1);
   localparam logic [RW-1:0] LastRow  = RW'(IN_ROWS - 1);
   localparam logic [PIXEL_BIT_WIDTH-1:0] PadPix = PIXEL_BIT_WIDTH'(PAD_VALUE);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                       state_q, state_d;
   logic [CW-1:0]                x0_q, x0_d, ncol_q, ncol_d, col_q, col_d;
   logic [RW-1:0]                y0_q, y0_d, nrow_q, nrow_d, row_q, row_d;
   logic                         tvalid_q, tvalid_d;
   logic [PIXEL_BIT_WIDTH-1:0]   tdata_q, tdata_d;
   logic [USER_WIDTH-1:0]        tuser_q, tuser_d;
   logic                         done_q, done_d;

   logic free, col_in, row_in, win, load;
   logic [CW-1:0] x0_clamp;
   logic [RW-1:0] y0_clamp;

   logic unused_tuser;
   assign unused_tuser = ^s_axis_tuser;

   assign x0_clamp = ({1'b0, crop_x0} > MaxX0) ? MaxX0[CW-1:0] : crop_x0;
   assign y0_clamp = ({1'b0, crop_y0} > MaxY0) ? MaxY0[RW-1:0] : crop_y0;

   // One extra bit so x0 + OUT_COLS never wraps.
   assign col_in = ({1'b0, ncol_q} >= {1'b0, x0_q}) && ({1'b0, ncol_q} < ({1'b0, x0_q} + WinCols));
   assign row_in = ({1'b0, nrow_q} >= {1'b0, y0_q}) && ({1'b0, nrow_q} < ({1'b0, y0_q} + WinRows));
   assign win    = col_in && row_in;
   assign free   = !tvalid_q || m_axis_tready;

   always_comb begin
      state_d       = state_q;
      x0_d          = x0_q;
      y0_d          = y0_q;
      ncol_d        = ncol_q;
      nrow_d        = nrow_q;
      col_d         = col_q;
      row_d         = row_q;
      tvalid_d      = tvalid_q;
      tdata_d       = tdata_q;
      tuser_d       = tuser_q;
      done_d        = 1'b0;
      load          = 1'b0;
      s_axis_tready = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A start coinciding with the done pulse is deliberately dropped.
            if (ap_start && !done_q) begin
               x0_d    = x0_clamp;
               y0_d    = y0_clamp;
               ncol_d  = '0;
               nrow_d  = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            s_axis_tready = free && win;
            load          = free && (!win || s_axis_tvalid);
            if (load) begin
               tvalid_d   = 1'b1;
               tdata_d    = win ? s_axis_tdata : PadPix;
               col_d      = ncol_q;
               row_d      = nrow_q;
               tuser_d    = '0;
               tuser_d[0] = (ncol_q == '0) && (nrow_q == '0);
               tuser_d[1] = (ncol_q == LastCol);
               if (ncol_q == LastCol) begin
                  ncol_d = '0;
                  nrow_d = nrow_q + 1'b1;
               end else begin
                  ncol_d = ncol_q + 1'b1;
               end
               if ((ncol_q == LastCol) && (nrow_q == LastRow)) begin
                  state_d = StDrain;
               end
            end else if (m_axis_tready) begin
               tvalid_d = 1'b0;
            end
         end
         StDrain: begin
            if (tvalid_q && m_axis_tready) begin
               tvalid_d = 1'b0;
               done_d   = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge s_axis_resetn) begin
      if (!s_axis_resetn) begin
         state_q  <= StIdle;
         x0_q     <= '0;
         y0_q     <= '0;
         ncol_q   <= '0;
         nrow_q   <= '0;
         col_q    <= '0;
         row_q    <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tuser_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         ncol_q   <= ncol_d;
         nrow_q   <= nrow_d;
         col_q    <= col_d;
         row_q    <= row_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         tuser_q  <= tuser_d;
         done_q   <= done_d;
      end
   end

   assign ap_done       = done_q;
   assign ap_idle       = (state_q == StIdle);
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tuser  = tuser_q;
   assign cnt_col       = col_q;
   assign cnt_row       = row_q;

endmodule
